// File: rtl/sumator_serial_if.sv
// rtl/sumator_serial_if.sv - operand/result bundle for the bit-serial adder
interface sumator_serial_if #(parameter int WIDTH = 8);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/sumator_serial.sv
// rtl/sumator_serial.sv - bit-serial add/subtract, one bit per clock, LSB first
module sumator_serial #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    sumator_serial_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, sum_q;
    logic [CW-1:0]    cnt;
    logic             carry, cout_q, ovf_q;
    logic             bit_s, carry_nx, last;
    logic [WIDTH-1:0] s_nx;

    always_comb begin
        bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nx = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        last     = (cnt == CW'(WIDTH - 1));
        // New bit enters at the MSB so the word is LSB-aligned after WIDTH shifts.
        s_nx     = (s_sr >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
                    a_sr  <= bus.a;
                    b_sr  <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub;
                    s_sr  <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_nx;
                    carry <= carry_nx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // carry here is the carry into the MSB.
                        sum_q  <= s_nx;
                        cout_q <= carry_nx;
                        ovf_q  <= carry ^ carry_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_sumator_serial.sv
// tb/tb_sumator_serial.sv - randomized and directed checks of sumator_serial
module tb_sumator_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    sumator_serial_if #(.WIDTH(8)) b8();
    sumator_serial_if #(.WIDTH(1)) b1();

    sumator_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    sumator_serial #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] es, output logic ec, output logic eo);
        longint ua, ub, full, sa, sb, r, lim;
        ua   = longint'(a) & ((64'd1 << w) - 1);
        ub   = longint'(b) & ((64'd1 << w) - 1);
        full = s ? ua + ((1 << w) - ub) : ua + ub;
        if (s && ub == 0) full = ua + (1 << w);
        es   = 64'(full & ((1 << w) - 1));
        ec   = full[w];
        lim  = 1 << (w - 1);
        sa   = (ua >= lim) ? ua - (1 << w) : ua;
        sb   = (ub >= lim) ? ub - (1 << w) : ub;
        r    = s ? sa - sb : sa + sb;
        eo   = (r < -lim) || (r > lim - 1);
    endtask

    // One operation on either instance; start stays high and operands churn while busy.
    task automatic op(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                      output logic [63:0] rs, output logic rc, output logic ro);
        int cyc, busy_cnt;
        logic [63:0] es;
        logic ec, eo, dn, bz;
        @(negedge clk);
        if (w == 8) begin b8.start = 1; b8.a = a[7:0]; b8.b = b[7:0]; b8.sub = s; end
        else        begin b1.start = 1; b1.a = a[0];   b1.b = b[0];   b1.sub = s; end
        @(posedge clk); #1;
        cyc = 0; busy_cnt = 0;
        dn = (w == 8) ? b8.done : b1.done;
        while (!dn && cyc < 40) begin
            bz = (w == 8) ? b8.busy : b1.busy;
            if (bz) busy_cnt++;
            if (w == 8) begin b8.a = 8'($urandom); b8.b = 8'($urandom); b8.sub = 1'($urandom); end
            else        begin b1.a = 1'($urandom); b1.b = 1'($urandom); b1.sub = 1'($urandom); end
            @(posedge clk); #1;
            cyc++;
            dn = (w == 8) ? b8.done : b1.done;
        end
        if (w == 8) begin b8.start = 0; rs = 64'(b8.sum); rc = b8.cout; ro = b8.ovf; end
        else        begin b1.start = 0; rs = 64'(b1.sum); rc = b1.cout; ro = b1.ovf; end
        model(w, a, b, s, es, ec, eo);
        check("latency", 64'(cyc), 64'(w));
        check("busy_cycles", 64'(busy_cnt), 64'(w));
        check("sum", rs, es);
        check("cout", 64'(rc), 64'(ec));
        check("ovf", 64'(ro), 64'(eo));
        @(posedge clk); #1;
        check("done_pulse_end", 64'((w == 8) ? b8.done : b1.done), 64'd0);
        check("idle_not_busy", 64'((w == 8) ? b8.busy : b1.busy), 64'd0);
        check("sum_hold", 64'((w == 8) ? b8.sum : b1.sum), es);
    endtask

    logic [63:0] rs, es;
    logic        rc, ro, ec, eo;
    logic [7:0]  ra [0:39];
    logic [7:0]  rb [0:39];
    logic        rsb[0:39];

    initial begin
        b8.start = 0; b8.sub = 0; b8.a = '0; b8.b = '0;
        b1.start = 0; b1.sub = 0; b1.a = '0; b1.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(b8.busy), 0);
        check("rst_done", 64'(b8.done), 0);
        check("rst_sum", 64'(b8.sum), 0);
        check("rst_cout", 64'(b8.cout), 0);
        check("rst_ovf", 64'(b8.ovf), 0);
        check("rst_sum_w1", 64'(b1.sum), 0);
        rst_n = 1;

        op(8, 200, 100, 0, rs, rc, ro);
        check("v200p100_sum", rs, 44); check("v200p100_cout", 64'(rc), 1); check("v200p100_ovf", 64'(ro), 0);
        op(8, 127, 1, 0, rs, rc, ro);
        check("v127p1_sum", rs, 128); check("v127p1_cout", 64'(rc), 0); check("v127p1_ovf", 64'(ro), 1);
        op(8, 5, 7, 1, rs, rc, ro);
        check("v5m7_sum", rs, 254); check("v5m7_cout", 64'(rc), 0); check("v5m7_ovf", 64'(ro), 0);
        op(8, 128, 1, 1, rs, rc, ro);
        check("v128m1_sum", rs, 127); check("v128m1_cout", 64'(rc), 1); check("v128m1_ovf", 64'(ro), 1);
        op(8, 0, 0, 1, rs, rc, ro);
        op(8, 255, 255, 0, rs, rc, ro);

        for (int i = 0; i < 16; i++)
            op(8, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'($urandom), rs, rc, ro);

        // start held high: acceptances fall on every tenth edge.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            ra[k] = 8'($urandom); rb[k] = 8'($urandom); rsb[k] = 1'($urandom);
            b8.start = 1; b8.a = ra[k]; b8.b = rb[k]; b8.sub = rsb[k];
            @(posedge clk); #1;
            check("cont_done", 64'(b8.done), 64'((k % 10) == 8));
            if ((k % 10) == 8) begin
                model(8, 64'(ra[k-8]), 64'(rb[k-8]), rsb[k-8], es, ec, eo);
                check("cont_sum", 64'(b8.sum), es);
                check("cont_cout", 64'(b8.cout), 64'(ec));
                check("cont_ovf", 64'(b8.ovf), 64'(eo));
            end
        end
        @(negedge clk);
        b8.start = 0;
        @(posedge clk); #1;

        // Reset during RUN cycle 4.
        @(negedge clk);
        b8.start = 1; b8.a = 9; b8.b = 9; b8.sub = 0;
        @(posedge clk); #1;
        b8.start = 0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(b8.busy), 1);
        rst_n = 0;
        #1;
        check("abort_busy", 64'(b8.busy), 0);
        check("abort_done", 64'(b8.done), 0);
        check("abort_sum", 64'(b8.sum), 0);
        check("abort_cout", 64'(b8.cout), 0);
        check("abort_ovf", 64'(b8.ovf), 0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("abort_no_done", 64'(b8.done), 0);
            if (k == 2) rst_n = 1;
        end
        // Release just after an edge so the very next edge is the first with rst_n=1.
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        op(8, 3, 4, 0, rs, rc, ro);
        check("after_rst_sum", rs, 7);

        op(1, 1, 1, 0, rs, rc, ro);
        check("w1_sum", rs, 0); check("w1_cout", 64'(rc), 1); check("w1_ovf", 64'(ro), 1);
        for (int i = 0; i < 8; i++)
            op(1, 64'(i[0]), 64'(i[1]), i[2], rs, rc, ro);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sumator_serial.md
SUMATOR_SERIAL -- requirements
Module: sumator_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 Reset is asynchronous and active-low; single clock domain.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement; sampled with start.
REQ-008 b  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  single-cycle pulse; results valid.
REQ-011 sum  output  WIDTH  registered result.
REQ-012 cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL capture a, capture b (or ~b if sub=1), preset the carry flop to sub, clear the bit counter and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE and all outputs SHALL hold.
REQ-017 Each RUN cycle SHALL process one bit, LSB first, with a full-adder slice: s = a_i ^ b_i ^ c and c_next = a_i&b_i | c&(a_i^b_i).
REQ-018 The bit counter SHALL be max($clog2(WIDTH),1) bits wide; RUN SHALL last exactly WIDTH cycles.
REQ-019 On the edge that processes bit WIDTH-1, the block SHALL load sum, cout and ovf in parallel and enter DONE.
REQ-020 The carry into the MSB SHALL be retained for ovf; for WIDTH=1 it is the initial carry.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-022 With start sampled at edge E0, done SHALL be high in the cycle following edge E(WIDTH).
REQ-023 start in RUN or DONE SHALL be ignored, with no queuing; a, b and sub changes in those states SHALL have no effect.
REQ-024 sum, cout and ovf SHALL change only on the completion edge and SHALL hold until the next completion.
REQ-025 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-026 Partial results SHALL be kept in internal shift registers and never appear on sum.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE, and busy, done, sum, cout, ovf, the carry flop, the counter and the operand registers SHALL all be 0.
REQ-028 An assertion of rst_n mid-RUN SHALL abort immediately, with no done pulse and outputs at 0.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which rst_n=1.

Verification
REQ-030 WIDTH=8, add, a=200, b=100 -> done 8 cycles after start; sum=44, cout=1, ovf=0.
REQ-031 WIDTH=8, add, a=127, b=1 -> sum=128, cout=0, ovf=1; busy high for exactly 8 cycles.
REQ-032 WIDTH=8, sub, a=5, b=7 -> sum=254, cout=0, ovf=0; then sub, a=128, b=1 -> sum=127, cout=1, ovf=1.
REQ-033 WIDTH=8, start held high continuously with changing a and b -> one operation per 10 cycles (8 RUN, 1 DONE, 1 IDLE); each result uses only the operands sampled in IDLE.
REQ-034 rst_n pulsed low at RUN cycle 4 -> busy=0, done never pulses, sum/cout/ovf=0; next add 3+4 -> sum=7.
REQ-035 WIDTH=1, add, a=1, b=1 -> done 1 cycle after start; sum=0, cout=1, ovf=1.
